// File: rtl/mac_filtro_recursivo_if.sv
// mac_filtro_recursivo_if: sample strobe, latched operands and result/status lines of one IIR section.
interface mac_filtro_recursivo_if #(
  parameter int WIDTH = 22
);
  logic                    start;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] coef_b0;
  logic signed [WIDTH-1:0] coef_b1;
  logic signed [WIDTH-1:0] coef_b2;
  logic signed [WIDTH-1:0] coef_a1;
  logic signed [WIDTH-1:0] coef_a2;
  logic signed [WIDTH-1:0] y_out;
  logic                    done;
  logic                    busy;
  modport master (
    output start, x_in, coef_b0, coef_b1, coef_b2, coef_a1, coef_a2,
    input  y_out, done, busy
  );
  modport slave (
    input  start, x_in, coef_b0, coef_b1, coef_b2, coef_a1, coef_a2,
    output y_out, done, busy
  );
endinterface

// File: rtl/mac_filtro_recursivo.sv
// mac_filtro_recursivo: second-order IIR section, one shared multiplier, one term per clock, saturated output.
module mac_filtro_recursivo #(
  parameter int WIDTH = 22,
  parameter int FRAC  = 14
) (
  input logic                  clk,
  input logic                  rst_n,
  mac_filtro_recursivo_if.slave bus
);
  localparam int ACC = 2*WIDTH + 3;
  typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;
  state_t r_state, w_next;
  logic signed [WIDTH-1:0] r_x0, r_x1, r_x2, r_y1, r_y2, r_y_out;
  logic signed [WIDTH-1:0] r_b0, r_b1, r_b2, r_a1, r_a2;
  logic signed [ACC-1:0]   r_acc;
  logic [2:0]              r_k;
  logic                    r_done;
  logic signed [WIDTH-1:0]   w_ma, w_mb, w_sat;
  logic signed [2*WIDTH-1:0] w_ma_ext, w_mb_ext, w_prod;
  logic signed [ACC-1:0]     w_ext, w_term, w_r, w_max, w_min;
  assign w_ma = r_k == 3'd0 ? r_b0 : r_k == 3'd1 ? r_b1 : r_k == 3'd2 ? r_b2 : r_k == 3'd3 ? r_a1 : r_a2;
  assign w_mb = r_k == 3'd0 ? r_x0 : r_k == 3'd1 ? r_x1 : r_k == 3'd2 ? r_x2 : r_k == 3'd3 ? r_y1 : r_y2;
  assign w_ma_ext = {{WIDTH{w_ma[WIDTH-1]}}, w_ma};
  assign w_mb_ext = {{WIDTH{w_mb[WIDTH-1]}}, w_mb};
  assign w_prod   = w_ma_ext * w_mb_ext;
  assign w_ext    = {{(ACC-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
  // Denominator terms (k=3,4) are subtracted.
  assign w_term   = r_k >= 3'd3 ? -w_ext : w_ext;
  assign w_r      = r_acc >>> FRAC;
  assign w_max    = {{(ACC-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  assign w_min    = {{(ACC-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  assign w_sat    = w_r > w_max ? w_max[WIDTH-1:0] : w_r < w_min ? w_min[WIDTH-1:0] : w_r[WIDTH-1:0];
  always_comb begin
    w_next = r_state == IDLE ? (bus.start ? MAC : IDLE) :
             r_state == MAC  ? (r_k == 3'd4 ? ROUND : MAC) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x0 <= '0; r_x1 <= '0; r_x2 <= '0; r_y1 <= '0; r_y2 <= '0; r_y_out <= '0;
      r_b0 <= '0; r_b1 <= '0; r_b2 <= '0; r_a1 <= '0; r_a2 <= '0;
      r_acc <= '0;
      r_k <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE && bus.start) begin
        r_x0 <= bus.x_in;
        r_b0 <= bus.coef_b0; r_b1 <= bus.coef_b1; r_b2 <= bus.coef_b2;
        r_a1 <= bus.coef_a1; r_a2 <= bus.coef_a2;
        r_acc <= '0;
        r_k <= '0;
      end
      if (r_state == MAC) begin
        r_acc <= r_acc + w_term;
        r_k <= r_k + 3'd1;
      end
      if (r_state == ROUND) begin
        r_y_out <= w_sat;
        r_done <= 1'b1;
        r_x2 <= r_x1; r_x1 <= r_x0;
        r_y2 <= r_y1; r_y1 <= w_sat;
      end
    end
  end
  assign bus.y_out = r_y_out;
  assign bus.done  = r_done;
  assign bus.busy  = r_state != IDLE;
endmodule

// File: tb/tb_mac_filtro_recursivo.sv
// tb_mac_filtro_recursivo: directed vectors, scoreboard queue of expected results and done cycles, separate monitor.
module tb_mac_filtro_recursivo;
  localparam int W = 22;
  typedef struct {int y; int c;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  exp_t sb[$];
  mac_filtro_recursivo_if #(.WIDTH(W)) bus();
  mac_filtro_recursivo #(.WIDTH(W), .FRAC(14)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (bus.done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("y_out", int'($signed(bus.y_out)), e.y);
        check("done_cycle", cyc, e.c);
        check("busy_in_done", int'(bus.busy), 0);
      end
    end
  end
  task automatic set_in(input int x, b0, b1, b2, a1, a2);
    bus.x_in = W'(x);
    bus.coef_b0 = W'(b0); bus.coef_b1 = W'(b1); bus.coef_b2 = W'(b2);
    bus.coef_a1 = W'(a1); bus.coef_a2 = W'(a2);
  endtask
  task automatic issue(input bit push, input int x, b0, b1, b2, a1, a2, y_exp);
    set_in(x, b0, b1, b2, a1, a2);
    bus.start = 1'b1;
    if (push) sb.push_back('{y_exp, cyc + 7});
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    check("drain_timeout", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask
  task automatic do_reset();
    bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    int d0;
    bus.start = 1'b1;
    set_in(1000, 16384, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_y_out", int'($signed(bus.y_out)), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_busy", int'(bus.busy), 0);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", int'(bus.busy), 0);
    // pass-through with busy window
    issue(1'b1, 1000, 16384, 0, 0, 0, 0, 1000);
    for (int i = 0; i < 6; i++) begin
      check("busy_window", int'(bus.busy), 1);
      @(negedge clk);
    end
    check("done_after_busy", int'(bus.done), 1);
    drain();
    // recursion y = x - (-0.5) y1
    do_reset();
    issue(1'b1, 16384, 16384, 0, 0, -8192, 0, 16384); drain();
    issue(1'b1, 0, 16384, 0, 0, -8192, 0, 8192);      drain();
    issue(1'b1, 0, 16384, 0, 0, -8192, 0, 4096);      drain();
    issue(1'b1, 0, 16384, 0, 0, -8192, 0, 2048);      drain();
    // saturation
    do_reset();
    issue(1'b1, 2097151, 32768, 0, 0, 0, 0, 2097151);   drain();
    issue(1'b1, -2097152, 32768, 0, 0, 0, 0, -2097152); drain();
    do_reset();
    issue(1'b1, 1500000, 16384, 16384, 0, 0, 0, 1500000); drain();
    issue(1'b1, 1500000, 16384, 16384, 0, 0, 0, 2097151); drain();
    // ignored starts while busy, then start in the done cycle
    do_reset();
    d0 = n_done;
    issue(1'b1, 700, 16384, 0, 0, 0, 0, 700);
    set_in(9999, 16384, 0, 0, 0, 0);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0; @(negedge clk);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
    check("done_seen", int'(bus.done), 1);
    issue(1'b1, 300, 16384, 0, 0, 0, 0, 300);
    drain();
    repeat (10) @(negedge clk);
    check("done_count_handshake", n_done - d0, 2);
    // coefficient change while busy uses latched copies
    do_reset();
    issue(1'b1, 1000, 16384, 0, 0, 0, 0, 1000);
    set_in(5, 0, 16384, 16384, -16384, 9000);
    drain();
    // abort mid-operation, then confirm cleared history
    d0 = n_done;
    issue(1'b0, 1000, 16384, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    issue(1'b1, 500, 16384, 0, 0, -8192, 0, 500);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
